// File: rtl/riscv_imm_pkg.sv
// Shared types for the RISC-V immediate-extension stage: format select
// encoding, default datapath width and the buffered entry layout.
package riscv_imm_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam int unsigned ILEN         = 32;

   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_B    = 3'd2,
      IMM_J    = 3'd3,
      IMM_U    = 3'd4,
      IMM_Z    = 3'd5,
      IMM_SH   = 3'd6,
      IMM_RSVD = 3'd7
   } imm_src_e;

   // Entry layout at the default width; wider builds use the same field order.
   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] imm;
      logic [XLEN_DEFAULT-1:0] target;
      logic                    illegal;
   } imm_entry_t;

endpackage

// File: rtl/imm_dec.sv
// Combinational RISC-V immediate decoder: instruction bits + format select
// to an XLEN-wide extended immediate and a reserved-format flag.
module imm_dec
   import riscv_imm_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic [ILEN-1:7] instr,
   input  logic [2:0]      imm_src,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   logic       s;
   logic [31:0] raw;

   assign s       = instr[31];
   assign illegal = (imm_src_e'(imm_src) == IMM_RSVD);

   // Every format is built as a 32-bit value whose bit 31 is the correct
   // extension bit, so widening to XLEN is always a sign extension.
   always_comb begin
      raw = '0;
      case (imm_src_e'(imm_src))
         IMM_S:   raw = {{20{s}}, instr[31:25], instr[11:7]};
         IMM_B:   raw = {{19{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_J:   raw = {{11{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_U:   raw = {instr[31:12], 12'b0};
         IMM_Z:   raw = {27'b0, instr[19:15]};
         IMM_SH:  raw = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
         default: raw = {{20{s}}, instr[31:20]};
      endcase
   end

   if (XLEN > 32) begin : g_wide
      assign imm = {{(XLEN-32){raw[31]}}, raw};
   end else begin : g_narrow
      assign imm = raw;
   end

endmodule

// File: rtl/imm_ext_stage.sv
// Pipelined immediate-extension stage with valid/ready handshake and a
// two-entry (OUT + SKID) buffer. Define IMM_TARGET_EN to add pc + imm target.
module imm_ext_stage
   import riscv_imm_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [ILEN-1:0] instr,
   input  logic [2:0]      imm_src,
   input  logic [XLEN-1:0] pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm_ext,
   output logic [XLEN-1:0] target,
   output logic            imm_illegal
);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] target;
      logic            illegal;
   } entry_t;

   entry_t          out_q, out_d, skid_q, skid_d, new_entry;
   logic            out_valid_q, out_valid_d;
   logic            skid_valid_q, skid_valid_d;
   logic            in_ready_q, in_ready_d;
   logic            accept, drain;
   logic [XLEN-1:0] dec_imm;
   logic            dec_illegal;
   logic            unused_opcode;

   assign unused_opcode = ^instr[6:0];

   imm_dec #(.XLEN(XLEN)) u_dec (
      .instr   (instr[ILEN-1:7]),
      .imm_src (imm_src),
      .imm     (dec_imm),
      .illegal (dec_illegal)
   );

`ifdef IMM_TARGET_EN
   assign new_entry = '{imm: dec_imm, target: dec_imm + pc, illegal: dec_illegal};
`else
   logic unused_pc;
   assign unused_pc = ^pc;
   assign new_entry = '{imm: dec_imm, target: '0, illegal: dec_illegal};
`endif

   assign accept = in_valid & in_ready_q;
   assign drain  = out_valid_q & out_ready;

   // Buffer next-state: SKID always refills OUT first so order is preserved.
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (drain) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_d = new_entry;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!out_valid_q) begin
            out_d       = new_entry;
            out_valid_d = 1'b1;
         end else begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
         end
      end
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end
      in_ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign imm_ext     = out_q.imm;
   assign target      = out_q.target;
   assign imm_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed self-checking bench for imm_ext_stage; runs an XLEN=32 and an
// XLEN=64 instance side by side on the same stimulus.
module tb_imm_ext_stage;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] instr;
   logic [2:0]  imm_src;
   logic [63:0] pc;

   logic        in_ready32, out_valid32, ill32;
   logic [31:0] imm32, tgt32;
   logic        in_ready64, out_valid64, ill64;
   logic [63:0] imm64, tgt64;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   imm_ext_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(in_ready32), .instr(instr), .imm_src(imm_src), .pc(pc[31:0]),
      .out_valid(out_valid32), .out_ready(out_ready), .imm_ext(imm32),
      .target(tgt32), .imm_illegal(ill32)
   );

   imm_ext_stage #(.XLEN(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(in_ready64), .instr(instr), .imm_src(imm_src), .pc(pc),
      .out_valid(out_valid64), .out_ready(out_ready), .imm_ext(imm64),
      .target(tgt64), .imm_illegal(ill64)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_tgt(input logic [63:0] sum);
`ifdef IMM_TARGET_EN
      return sum;
`else
      return 64'(sum & 64'd0);
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] s, input logic [63:0] p);
      in_valid = v;
      instr    = i;
      imm_src  = s;
      pc       = p;
   endtask

   typedef struct {
      string       tag;
      logic [31:0] instr;
      logic [2:0]  src;
      logic [63:0] pc;
      logic [31:0] e32;
      logic [63:0] e64;
      logic        ill;
   } vec_t;

   vec_t vecs[$];

   initial begin
      vecs.push_back('{"I",    32'hFFF00093, 3'd0, 64'h0,   32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0});
      vecs.push_back('{"B",    32'hFE000EE3, 3'd2, 64'h100, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0});
      vecs.push_back('{"U",    32'h800000B7, 3'd4, 64'h0,   32'h80000000, 64'hFFFFFFFF80000000, 1'b0});
      vecs.push_back('{"J",    32'h0080006F, 3'd3, 64'h40,  32'h00000008, 64'h0000000000000008, 1'b0});
      vecs.push_back('{"S",    32'hFE112E23, 3'd1, 64'h100, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0});
      vecs.push_back('{"Z",    32'h800F8073, 3'd5, 64'h0,   32'h0000001F, 64'h000000000000001F, 1'b0});
      vecs.push_back('{"SH",   32'h83F00013, 3'd6, 64'h0,   32'h0000001F, 64'h000000000000003F, 1'b0});
      vecs.push_back('{"RSVD", 32'h00500093, 3'd7, 64'h0,   32'h00000005, 64'h0000000000000005, 1'b1});

      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 32'h0, 3'd0, 64'h0);
      step();
      check("rst_out_valid", 64'(out_valid32), 64'd0);
      check("rst_in_ready", 64'(in_ready32), 64'd1);
      check("rst_imm", 64'(imm32), 64'd0);
      check("rst_target", 64'(tgt32), 64'd0);
      check("rst_illegal", 64'(ill32), 64'd0);
      rst_n = 1'b1;
      step();

      // Back-to-back stream with out_ready high: one result per cycle.
      foreach (vecs[k]) begin
         drive(1'b1, vecs[k].instr, vecs[k].src, vecs[k].pc);
         step();
         check({vecs[k].tag, "_valid"}, 64'(out_valid32), 64'd1);
         check({vecs[k].tag, "_imm32"}, 64'(imm32), 64'(vecs[k].e32));
         check({vecs[k].tag, "_imm64"}, imm64, vecs[k].e64);
         check({vecs[k].tag, "_ill"}, 64'(ill32), 64'(vecs[k].ill));
         check({vecs[k].tag, "_ill64"}, 64'(ill64), 64'(vecs[k].ill));
         check({vecs[k].tag, "_tgt32"}, 64'(tgt32),
               exp_tgt(64'(32'(vecs[k].pc[31:0] + vecs[k].e32))));
         check({vecs[k].tag, "_tgt64"}, tgt64, exp_tgt(vecs[k].pc + vecs[k].e64));
         check({vecs[k].tag, "_in_ready"}, 64'(in_ready32), 64'd1);
      end
      drive(1'b0, 32'h0, 3'd0, 64'h0);
      step();
      check("drain_empty", 64'(out_valid32), 64'd0);

      // Stall: three back-to-back inputs against out_ready low.
      out_ready = 1'b0;
      drive(1'b1, 32'h00100093, 3'd0, 64'h0);
      step();
      check("stall_a_valid", 64'(out_valid32), 64'd1);
      check("stall_a_imm", 64'(imm32), 64'd1);
      check("stall_a_ready", 64'(in_ready32), 64'd1);
      drive(1'b1, 32'h00200093, 3'd0, 64'h0);
      step();
      check("stall_b_imm", 64'(imm32), 64'd1);
      check("stall_b_ready", 64'(in_ready32), 64'd0);
      drive(1'b1, 32'h00300093, 3'd0, 64'h0);
      step();
      check("stall_c_imm", 64'(imm32), 64'd1);
      check("stall_c_ready", 64'(in_ready32), 64'd0);
      step();
      check("stall_hold_imm", 64'(imm32), 64'd1);
      check("stall_hold_valid", 64'(out_valid32), 64'd1);
      out_ready = 1'b1;
      step();
      check("release_b_imm", 64'(imm32), 64'd2);
      check("release_b_ready", 64'(in_ready32), 64'd1);
      step();
      check("release_c_imm", 64'(imm32), 64'd3);
      check("release_c_valid", 64'(out_valid32), 64'd1);
      drive(1'b0, 32'h0, 3'd0, 64'h0);
      step();
      check("release_empty", 64'(out_valid32), 64'd0);

      // Flush with SKID full and a pending input.
      out_ready = 1'b0;
      drive(1'b1, 32'h00400093, 3'd0, 64'h0);
      step();
      drive(1'b1, 32'h00500093, 3'd0, 64'h0);
      step();
      check("pre_flush_ready", 64'(in_ready32), 64'd0);
      flush = 1'b1;
      drive(1'b1, 32'h00600093, 3'd0, 64'h0);
      step();
      check("flush_valid", 64'(out_valid32), 64'd0);
      check("flush_ready", 64'(in_ready32), 64'd1);
      flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 32'h0, 3'd0, 64'h0);
      step();
      check("flush_nothing", 64'(out_valid32), 64'd0);

      // Flush dominates a same-cycle accept.
      out_ready = 1'b0;
      drive(1'b1, 32'h00700093, 3'd0, 64'h0);
      step();
      flush = 1'b1;
      drive(1'b1, 32'h00800093, 3'd0, 64'h0);
      step();
      check("flush_acc_valid", 64'(out_valid32), 64'd0);
      flush = 1'b0;
      drive(1'b0, 32'h0, 3'd0, 64'h0);
      step();
      check("flush_acc_gone", 64'(out_valid32), 64'd0);
      check("flush_acc_ready", 64'(in_ready32), 64'd1);

      // Reset mid-stall clears both entries asynchronously.
      drive(1'b1, 32'h00900093, 3'd0, 64'h0);
      step();
      drive(1'b1, 32'h00A00093, 3'd0, 64'h0);
      step();
      check("pre_rst_valid", 64'(out_valid32), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(out_valid32), 64'd0);
      check("async_rst_ready", 64'(in_ready32), 64'd1);
      check("async_rst_imm", 64'(imm32), 64'd0);
      check("async_rst_valid64", 64'(out_valid64), 64'd0);
      drive(1'b0, 32'h0, 3'd0, 64'h0);
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      check("post_rst_valid", 64'(out_valid32), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
